// File: rtl/shift_delay_checker_pkg.sv
// Shared types and defaults for the shift-delay checker.
// State encoding and default data/counter widths.
package shift_delay_checker_pkg;

  localparam int DEF_W  = 4;
  localparam int DEF_CW = 8;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

  // Warm-up counter width: DEPTH is at most 8.
  localparam int WARM_W = 4;

  function automatic logic [WARM_W-1:0] warm_last(input int depth);
    return WARM_W'(depth - 1);
  endfunction

endpackage

// File: rtl/shift_delay_checker_sat.sv
// Saturating up-counter with enable and synchronous clear.
// Ports: clk, clr (sync clear), en (count), cnt (holds at all-ones).
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_delay_checker.sv
// Checker that compares pipeline output c with a delayed shadow of a.
// Ports: clk, rst, en, a, c in; match, err, chk_cnt, err_cnt, first_exp, first_got, state out.
module shift_delay_checker
  import shift_delay_checker_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int DEPTH        = 2,
  parameter int CW           = DEF_CW,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  c,
  output logic          match,
  output logic          err,
  output logic [CW-1:0] chk_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [W-1:0]  first_exp,
  output logic [W-1:0]  first_got,
  output logic [1:0]    state
);

  logic [W-1:0] hist [DEPTH];
  logic [W-1:0] expv;

  state_t state_q;
  state_t state_d;

  logic [WARM_W-1:0] wcnt_q;
  logic [WARM_W-1:0] wcnt_d;

  logic shift;
  logic cmp;
  logic miss;

  assign expv  = hist[DEPTH-1];
  assign state = state_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    shift   = 1'b0;
    cmp     = 1'b0;
    miss    = 1'b0;
    if (!en) begin
      // Pipeline keeps moving while paused: refill history.
      wcnt_d = '0;
      if (state_q != ST_FAIL) begin
        state_d = ST_WARMUP;
      end
    end else begin
      unique case (state_q)
        ST_WARMUP: begin
          shift = 1'b1;
          if (wcnt_q == warm_last(DEPTH)) begin
            state_d = ST_CHECK;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WARM_W'(1);
          end
        end
        ST_CHECK: begin
          shift = 1'b1;
          cmp   = 1'b1;
          miss  = (c != expv);
          if (miss && STOP_ON_FAIL) begin
            state_d = ST_FAIL;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_WARMUP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WARMUP;
      wcnt_q    <= '0;
      match     <= 1'b0;
      err       <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      match   <= cmp && !miss;
      if (shift) begin
        hist[0] <= a;
        for (int i = 1; i < DEPTH; i++) begin
          hist[i] <= hist[i-1];
        end
      end
      if (cmp && miss) begin
        err <= 1'b1;
        // Only the first failing pair is kept.
        if (!err) begin
          first_exp <= expv;
          first_got <= c;
        end
      end
    end
  end

  sat_counter #(.CW(CW)) u_chk (
    .clk (clk),
    .clr (rst),
    .en  (cmp),
    .cnt (chk_cnt)
  );

  sat_counter #(.CW(CW)) u_err (
    .clk (clk),
    .clr (rst),
    .en  (cmp && miss),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_shift_delay_checker.sv
// Bench for shift_delay_checker: several checker configurations
// watching correct, collapsed and corrupted 4-bit pipelines.
module tb_shift_delay_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic       inj;
  logic [3:0] a;

  logic [3:0] b_nb;
  logic [3:0] c_nb;
  logic [3:0] c_bl;
  logic [3:0] c_sf;
  logic [3:0] c_cw;

  int n_pass;
  int n_tot;
  int n_chk;

  logic [3:0] sb_q [$];

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference pipelines: correct two-stage and collapsed one-stage.
  always @(posedge clk) begin
    b_nb <= a;
    c_nb <= b_nb;
    c_bl <= a;
  end

  assign c_sf = inj ? 4'h0 : c_nb;
  assign c_cw = ~c_nb;

  logic       nb_match, nb_err;
  logic [7:0] nb_chk, nb_ecnt;
  logic [3:0] nb_fe, nb_fg;
  logic [1:0] nb_st;

  logic       b2_match, b2_err;
  logic [7:0] b2_chk, b2_ecnt;
  logic [3:0] b2_fe, b2_fg;
  logic [1:0] b2_st;

  logic       b1_match, b1_err;
  logic [7:0] b1_chk, b1_ecnt;
  logic [3:0] b1_fe, b1_fg;
  logic [1:0] b1_st;

  logic       sf_match, sf_err;
  logic [7:0] sf_chk, sf_ecnt;
  logic [3:0] sf_fe, sf_fg;
  logic [1:0] sf_st;

  logic       cw_match, cw_err;
  logic [1:0] cw_chk, cw_ecnt;
  logic [3:0] cw_fe, cw_fg;
  logic [1:0] cw_st;

  shift_delay_checker #(.W(4), .DEPTH(2), .CW(8), .STOP_ON_FAIL(1'b0)) u_nb (
    .clk(clk), .rst(rst), .en(en), .a(a), .c(c_nb),
    .match(nb_match), .err(nb_err), .chk_cnt(nb_chk), .err_cnt(nb_ecnt),
    .first_exp(nb_fe), .first_got(nb_fg), .state(nb_st)
  );

  shift_delay_checker #(.W(4), .DEPTH(2), .CW(8), .STOP_ON_FAIL(1'b0)) u_b2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .c(c_bl),
    .match(b2_match), .err(b2_err), .chk_cnt(b2_chk), .err_cnt(b2_ecnt),
    .first_exp(b2_fe), .first_got(b2_fg), .state(b2_st)
  );

  shift_delay_checker #(.W(4), .DEPTH(1), .CW(8), .STOP_ON_FAIL(1'b0)) u_b1 (
    .clk(clk), .rst(rst), .en(en), .a(a), .c(c_bl),
    .match(b1_match), .err(b1_err), .chk_cnt(b1_chk), .err_cnt(b1_ecnt),
    .first_exp(b1_fe), .first_got(b1_fg), .state(b1_st)
  );

  shift_delay_checker #(.W(4), .DEPTH(2), .CW(8), .STOP_ON_FAIL(1'b1)) u_sf (
    .clk(clk), .rst(rst), .en(en), .a(a), .c(c_sf),
    .match(sf_match), .err(sf_err), .chk_cnt(sf_chk), .err_cnt(sf_ecnt),
    .first_exp(sf_fe), .first_got(sf_fg), .state(sf_st)
  );

  shift_delay_checker #(.W(4), .DEPTH(2), .CW(2), .STOP_ON_FAIL(1'b0)) u_cw (
    .clk(clk), .rst(rst), .en(en), .a(a), .c(c_cw),
    .match(cw_match), .err(cw_err), .chk_cnt(cw_chk), .err_cnt(cw_ecnt),
    .first_exp(cw_fe), .first_got(cw_fg), .state(cw_st)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge of stimulus; the scoreboard holds a values awaiting
  // their compare slot DEPTH=2 enabled edges later.
  task automatic step(input logic [3:0] av, input logic ev);
    logic       do_cmp;
    logic [3:0] exp_a;
    logic [3:0] got_c;
    do_cmp = 1'b0;
    exp_a  = '0;
    got_c  = c_nb;
    a  = av;
    en = ev;
    if (ev) begin
      if (sb_q.size() == 2) begin
        exp_a  = sb_q.pop_front();
        do_cmp = 1'b1;
      end
      sb_q.push_back(av);
    end else begin
      sb_q.delete();
    end
    tick();
    if (do_cmp) begin
      n_chk++;
      chk("nb_match", nb_match, got_c == exp_a);
      chk("nb_chk_cnt", nb_chk, n_chk);
    end else begin
      chk("nb_match_idle", nb_match, 0);
    end
  endtask

  logic [3:0] seq1 [6];

  initial begin
    n_pass = 0;
    n_tot  = 0;
    n_chk  = 0;
    rst = 1'b1;
    en  = 1'b0;
    inj = 1'b0;
    a   = 4'h0;
    seq1 = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2, 4'h2};
    tick();
    tick();
    rst = 1'b0;

    chk("rst_state", nb_st, 0);
    chk("rst_match", nb_match, 0);
    chk("rst_err", nb_err, 0);
    chk("rst_chk", nb_chk, 0);
    chk("rst_ecnt", nb_ecnt, 0);
    chk("rst_fexp", nb_fe, 0);
    chk("rst_fgot", nb_fg, 0);

    for (int i = 0; i < 6; i++) begin
      step(seq1[i], 1'b1);
      chk("b1_match", b1_match, (i >= 1) ? 1 : 0);
      if (i == 0) chk("nb_warm1", nb_st, 0);
      if (i == 1) chk("nb_warm2", nb_st, 1);
      if (i == 1) chk("nb_chk0", nb_chk, 0);
      if (i == 2) begin
        chk("b2_err", b2_err, 1);
        chk("b2_fexp", b2_fe, 4'h3);
        chk("b2_fgot", b2_fg, 4'h7);
        chk("b2_match", b2_match, 0);
      end
      if (i == 4) chk("b2_ecnt3", b2_ecnt, 3);
    end
    chk("nb_chk4", nb_chk, 4);
    chk("nb_err", nb_err, 0);
    chk("nb_ecnt", nb_ecnt, 0);
    chk("b2_ecnt4", b2_ecnt, 4);
    chk("b1_err", b1_err, 0);
    chk("b1_chk", b1_chk, 5);

    step(4'h5, 1'b1);
    step(4'h9, 1'b1);
    chk("cw_ecnt_sat", cw_ecnt, 3);
    chk("cw_chk_sat", cw_chk, 3);
    chk("cw_err", cw_err, 1);
    chk("cw_fexp", cw_fe, 4'h3);
    chk("cw_fgot", cw_fg, 4'hC);
    chk("sf_state_ok", sf_st, 1);

    inj = 1'b1;
    step(4'h1, 1'b1);
    inj = 1'b0;
    chk("sf_state_fail", sf_st, 2);
    chk("sf_ecnt", sf_ecnt, 1);
    chk("sf_chk", sf_chk, 7);
    chk("sf_fexp", sf_fe, 4'h5);
    chk("sf_fgot", sf_fg, 4'h0);
    step(4'h4, 1'b1);
    step(4'h6, 1'b1);
    chk("sf_frz_state", sf_st, 2);
    chk("sf_frz_chk", sf_chk, 7);
    chk("sf_frz_ecnt", sf_ecnt, 1);
    chk("sf_frz_match", sf_match, 0);

    step(4'h6, 1'b0);
    chk("nb_pause_st", nb_st, 0);
    step(4'h6, 1'b0);
    chk("nb_pause_st2", nb_st, 0);
    chk("sf_pause_st", sf_st, 2);
    step(4'h8, 1'b1);
    chk("nb_rewarm1", nb_st, 0);
    step(4'hB, 1'b1);
    chk("nb_rewarm2", nb_st, 1);
    step(4'h3, 1'b1);
    step(4'hE, 1'b1);
    chk("nb_err_end", nb_err, 0);
    chk("nb_ecnt_end", nb_ecnt, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    n_chk = 0;
    chk("sf_rst_state", sf_st, 0);
    chk("sf_rst_match", sf_match, 0);
    chk("sf_rst_err", sf_err, 0);
    chk("sf_rst_chk", sf_chk, 0);
    chk("sf_rst_ecnt", sf_ecnt, 0);
    chk("sf_rst_fexp", sf_fe, 0);
    chk("sf_rst_fgot", sf_fg, 0);
    chk("cw_rst_err", cw_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
